phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Parametrised multi-phase control sequencer; generalises the two-state toggle controller to NUM_PHASES rotating phases.
- Each phase lasts a programmable dwell time, followed by an optional all-off gap.
- Supports early advance, hold, and forced jump to any phase.
- Sits between the top-level controller and the output drivers; the one-hot output directly selects the active channel.

Parameters:
NUM_PHASES, 2, number of phases in rotation (>=2)
PHASE_W, 1, width of phase index; must satisfy 2**PHASE_W >= NUM_PHASES
CNT_W, 8, width of dwell counter and dwell_max
GAP_CYCLES, 1, all-off cycles inserted between phases (0 = direct switch)
MIN_DWELL, 2, minimum dwell_cnt at which an advance request is honoured

Ports:
clk_main  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run sequencer; 0 returns to IDLE
dwell_max  in  CNT_W  phase length minus one; sampled on phase entry
advance  in  1  early-advance request (level, sampled each cycle)
hold  in  1  freeze dwell counter and block expiry
force_valid  in  1  jump request
force_phase  in  PHASE_W  jump target
phase  out  PHASE_W  current/last phase index
phase_onehot  out  NUM_PHASES  one-hot of phase while ACTIVE, else 0
active  out  1  high in ACTIVE state
phase_change  out  1  one-cycle pulse, first ACTIVE cycle of each phase entry
dwell_cnt  out  CNT_W  cycles elapsed in current phase

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0): state IDLE; phase=0, phase_onehot=0, active=0, phase_change=0, dwell_cnt=0; internal gap counter and latched dwell_max are 0.
- Reset takes effect immediately, mid-operation included. Sequencing restarts from phase 0.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE: when enable=1, go to ACTIVE next cycle with the current phase value.
  - dwell_cnt=0, phase_change=1, dwell_max latched.
- ACTIVE: dwell_cnt increments by 1 per cycle unless hold=1.
  - Expiry: dwell_cnt==latched dwell_max and hold=0. Phase length is therefore dwell_max+1 cycles. dwell_max=0 gives a 1-cycle phase.
  - Advance: advance=1 and dwell_cnt>=MIN_DWELL. Honoured even while hold=1. Ignored below MIN_DWELL, with no memory of the request.
  - On expiry or advance:
    - GAP_CYCLES>0: go to GAP.
    - GAP_CYCLES=0: go directly to ACTIVE with the next phase, dwell_cnt=0, phase_change=1.
- GAP: phase_onehot=0, active=0, dwell_cnt held at 0, phase unchanged.
  - Stays GAP_CYCLES cycles, then ACTIVE with next phase, phase_change=1, dwell_max re-latched.
- Next phase = phase+1; wraps from NUM_PHASES-1 to 0.
- force_valid=1 with force_phase<NUM_PHASES, in any state while enable=1:
  - Next cycle: ACTIVE with phase=force_phase, dwell_cnt=0, phase_change=1, dwell_max latched.
  - Gap is skipped.
  - Forcing the current phase restarts its dwell and pulses phase_change.
- force_phase>=NUM_PHASES: request ignored, normal operation continues.
- Priority, highest first: reset_n, enable=0, valid force, expiry/advance, count.
- enable=0: IDLE next cycle; onehot=0, active=0, dwell_cnt=0; phase retained so resume continues the same phase with a fresh dwell.
- phase_change is never high for two consecutive cycles except back-to-back forces, or GAP_CYCLES=0 with dwell_max=0.
- dwell_cnt never exceeds latched dwell_max.

Test Plan:
(NUM_PHASES=3, GAP_CYCLES=1, MIN_DWELL=2, CNT_W=8, dwell_max=4 unless stated)
1. reset_n released, enable=1 at cycle 0 ->
   - cycle1: phase=0, onehot=001, phase_change=1.
   - cycles1-5: dwell_cnt 0..4.
   - cycle6: gap, onehot=000, active=0.
   - cycle7: phase=1, onehot=010, phase_change=1.
2. Run through phase 2 expiry -> one gap cycle, then phase=0, onehot=001 (wrap).
3. advance=1 at dwell_cnt=1 -> ignored, phase unchanged. advance=1 at dwell_cnt=2 -> GAP next cycle, then next phase.
4. force_valid=1, force_phase=2 during GAP -> next cycle ACTIVE, phase=2, onehot=100, dwell_cnt=0, phase_change=1. force_phase=3 -> no effect.
5. hold=1 for 10 cycles at dwell_cnt=3 -> dwell_cnt stays 3, no expiry. hold=0 -> dwell_cnt 4, then GAP.
6. reset_n=0 mid-phase 1 -> all outputs 0 before next clock edge. Separately, enable=0 at phase 1, dwell_cnt=2 -> IDLE. enable=1 -> phase=1, dwell_cnt=0, phase_change=1.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: rotating multi-phase control sequencer.
// Steps through NUM_PHASES phases, each lasting a programmable dwell,
// optionally separated by an all-off gap. Supports early advance, hold
// and forced jumps to any phase. All outputs are registered.
//
// Handshake note: there is no valid/ready pair here. force_valid is a
// single-cycle request that is acted on in the same cycle it is seen high
// (with a legal target and enable=1); it is never queued or acknowledged.
// advance is a level that is sampled each cycle and likewise not remembered.
module phase_sequencer #(
    parameter int NUM_PHASES = 2,
    parameter int PHASE_W    = 1,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MIN_DWELL  = 2
) (
    input  logic                  clk_main,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      dwell_max,
    input  logic                  advance,
    input  logic                  hold,
    input  logic                  force_valid,
    input  logic [PHASE_W-1:0]    force_phase,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  active,
    output logic                  phase_change,
    output logic [CNT_W-1:0]      dwell_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0]   MIN_CNT    = CNT_W'(MIN_DWELL);

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [CNT_W-1:0]   dwell_lat;

    logic               force_ok;
    logic               expire;
    logic               adv_ok;
    logic               step;
    logic               do_entry;
    logic [PHASE_W-1:0] next_phase;
    logic [PHASE_W-1:0] entry_phase;

    function automatic logic [NUM_PHASES-1:0] onehot_of(input logic [PHASE_W-1:0] p);
        return NUM_PHASES'(1) << p;
    endfunction

    // Decode the per-cycle decisions: legal force, expiry/advance, and
    // whether this cycle enters a new phase (and which one).
    always_comb begin
        force_ok    = force_valid && (force_phase <= LAST_PHASE);
        expire      = (dwell_cnt == dwell_lat) && !hold;
        adv_ok      = advance && (dwell_cnt >= MIN_CNT);
        step        = (state == ST_ACTIVE) && (expire || adv_ok);
        next_phase  = (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
        do_entry    = force_ok
                    || (state == ST_IDLE)
                    || (step && (GAP_CYCLES == 0))
                    || ((state == ST_GAP) && (gap_cnt == GAP_LAST));
        if (force_ok) begin
            entry_phase = force_phase;
        end else if (state == ST_IDLE) begin
            // Resume continues the phase that was running when disabled.
            entry_phase = phase;
        end else begin
            entry_phase = next_phase;
        end
    end

    // Sequencer FSM with registered outputs; enable=0 outranks any force,
    // and a force outranks expiry/advance and counting.
    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            phase        <= '0;
            phase_onehot <= '0;
            active       <= 1'b0;
            phase_change <= 1'b0;
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
            dwell_lat    <= '0;
        end else if (!enable) begin
            state        <= ST_IDLE;
            phase_onehot <= '0;
            active       <= 1'b0;
            phase_change <= 1'b0;
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
        end else if (do_entry) begin
            state        <= ST_ACTIVE;
            phase        <= entry_phase;
            phase_onehot <= onehot_of(entry_phase);
            active       <= 1'b1;
            phase_change <= 1'b1;
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
            dwell_lat    <= dwell_max;
        end else begin
            phase_change <= 1'b0;
            case (state)
                ST_ACTIVE: begin
                    if (step) begin
                        // Only reached with GAP_CYCLES>0; direct switch is an entry.
                        state        <= ST_GAP;
                        phase_onehot <= '0;
                        active       <= 1'b0;
                        dwell_cnt    <= '0;
                        gap_cnt      <= '0;
                    end else if (!hold) begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
